// File: rtl/multi_mem_ctrl.sv
// Request-side controller for the multi-cycle 16-bit memory.
// Holds each transaction on the memory bus and returns a one-cycle done/err.
module multi_mem_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           rdata,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out,
    input  logic                  mem_data_valid
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  mem_enable_q, mem_enable_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]           mem_data_in_q, mem_data_in_d;
    logic                  timeout_hit;

    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            mem_enable_q  <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            mem_enable_q  <= mem_enable_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req && !req_addr[0])
                    state_d = req_wr ? WRITE : READ;
            end
            WRITE: state_d = IDLE;
            READ: begin
                if (mem_data_valid || timeout_hit)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    mem_addr_d    = req_addr;
                    mem_data_in_d = req_wdata;
                    cnt_d         = '0;
                    done_d        = req_addr[0];
                    err_d         = req_addr[0];
                end
            end
            WRITE: done_d = 1'b1;
            READ: begin
                cnt_d = cnt_q + 8'd1;
                // valid beats a coincident timeout
                if (mem_data_valid) begin
                    rdata_d = mem_data_out;
                    done_d  = 1'b1;
                end else if (timeout_hit) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            default: ;
        endcase
        mem_enable_d = (state_d != IDLE);
        mem_wr_d     = (state_d == WRITE);
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign mem_enable  = mem_enable_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_multi_mem_ctrl.sv
// Directed bench for multi_mem_ctrl with a 4-stage flushing memory model
// and a scoreboard of expected completions.
module tb_multi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        busy, done, err;
    logic [15:0] rdata;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_mem_ctrl #(.ADDR_WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid)
    );

    // Memory model: valid 4 edges after enable, flushed when enable drops.
    logic [15:0] image [128];
    logic [3:0]  pv;
    logic [6:0]  pa0, pa1, pa2, pa3;
    logic        preload = 1'b0;
    logic        nov = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            image[0]  <= 16'h1111;
            image[1]  <= 16'h2222;
            image[2]  <= 16'h3333;
            image[16] <= 16'h5555;
        end else if (mem_enable && mem_wr) begin
            image[mem_addr[7:1]] <= mem_data_in;
        end
        if (!mem_enable || mem_wr) begin
            pv <= 4'b0;
        end else begin
            pv  <= {pv[2:0], 1'b1};
            pa0 <= mem_addr[7:1];
            pa1 <= pa0;
            pa2 <= pa1;
            pa3 <= pa2;
        end
    end

    assign mem_data_valid = pv[3] && !nov;
    assign mem_data_out   = image[pa3];

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          lat;
        int          en;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b0;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0 of the request.
    task automatic run_req(input string tag,
                           input logic wr,
                           input logic [15:0] addr,
                           input logic [15:0] wdata,
                           input logic e_err,
                           input logic [15:0] e_rdata,
                           input int e_lat,
                           input int e_en,
                           input int inj);
        exp_t e;
        int   k;
        int   en_cnt;
        bit   addr_ok;
        bit   got;
        sb.push_back('{e_err, e_rdata, e_lat, e_en});
        req = 1'b1; req_wr = wr;
        req_addr = addr; req_wdata = wdata;
        k = 0; en_cnt = 0; addr_ok = 1'b1; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            req = 1'b0;
            if (k == inj) begin
                req = 1'b1; req_wr = 1'b1;
                req_addr = 16'h0020; req_wdata = 16'hDEAD;
            end
            if (mem_enable) begin
                en_cnt++;
                if (mem_addr !== addr) addr_ok = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                e = sb.pop_front();
                chk({tag, "_lat"}, k, e.lat);
                chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
                chk({tag, "_rdata"}, {16'd0, rdata}, {16'd0, e.rdata});
                chk({tag, "_en_cycles"}, en_cnt, e.en);
                chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
                chk({tag, "_en_done"}, {31'd0, mem_enable}, 32'd0);
                chk({tag, "_addr_stable"}, {31'd0, addr_ok}, 32'd1);
            end
        end
        req = 1'b0;
        if (!got) begin
            void'(sb.pop_front());
            chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        end
    endtask

    int dones;

    initial begin
        rst = 1'b1; req = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0;
        preload = 1'b1;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_en", {31'd0, mem_enable}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_data_in}, 32'd0);
        rst = 1'b0;
        idle(2);

        run_req("wr10", 1'b1, 16'h0010, 16'hBEEF,
                1'b0, 16'h0000, 2, 1, 0);
        run_req("rd10", 1'b0, 16'h0010, 16'h0000,
                1'b0, 16'hBEEF, 6, 5, 0);
        run_req("rd00", 1'b0, 16'h0000, 16'h0000,
                1'b0, 16'h1111, 6, 5, 0);
        run_req("rd02", 1'b0, 16'h0002, 16'h0000,
                1'b0, 16'h2222, 6, 5, 0);
        run_req("rd04", 1'b0, 16'h0004, 16'h0000,
                1'b0, 16'h3333, 6, 5, 0);
        run_req("mis11", 1'b0, 16'h0011, 16'h0000,
                1'b1, 16'h3333, 1, 0, 0);
        idle(2);

        nov = 1'b1;
        run_req("tmo", 1'b0, 16'h0002, 16'h0000,
                1'b1, 16'h3333, 9, 8, 0);
        nov = 1'b0;
        idle(2);

        // reset asserted in cycle 3 of a read
        req = 1'b1; req_wr = 1'b0; req_addr = 16'h0004;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_en", {31'd0, mem_enable}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rstmid_no_done", dones, 32'd0);
        run_req("rd02b", 1'b0, 16'h0002, 16'h0000,
                1'b0, 16'h2222, 6, 5, 0);

        run_req("rd00i", 1'b0, 16'h0000, 16'h0000,
                1'b0, 16'h1111, 6, 5, 2);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("ign_one_done", dones, 32'd0);
        run_req("rd20", 1'b0, 16'h0020, 16'h0000,
                1'b0, 16'h5555, 6, 5, 0);
        idle(3);
        chk("rdata_hold", {16'd0, rdata}, 32'h5555);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
